// File: rtl/automat_rest.sv
// Change-return unit: pays a refund out one coin at a time over a req/ack
// handshake, using 100-bani coins first and 50-bani coins as fallback.
module automat_rest #(
  parameter int unsigned AMT_W      = 3,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             empty100,
  input  logic             ack,
  output logic             out50,
  output logic             out100,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL      = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rest, rest_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             out50_nxt, out100_nxt;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rest    <= '0;
      gap_cnt <= '0;
      out50   <= 1'b0;
      out100  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rest    <= rest_nxt;
      gap_cnt <= gap_nxt;
      out50   <= out50_nxt;
      out100  <= out100_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt  = state;
    rest_nxt   = rest;
    gap_nxt    = gap_cnt;
    out50_nxt  = out50;
    out100_nxt = out100;
    case (state)
      IDLE: begin
        out50_nxt  = 1'b0;
        out100_nxt = 1'b0;
        if (start) begin
          rest_nxt  = amount;
          state_nxt = (amount == '0) ? DONE : SEL;
        end
      end
      SEL: begin
        // 100-bani coin only when at least two units remain, so rest never wraps
        if ((rest > AMT_W'(1)) && !empty100) begin
          out100_nxt = 1'b1;
          rest_nxt   = rest - AMT_W'(2);
        end else begin
          out50_nxt = 1'b1;
          rest_nxt  = rest - AMT_W'(1);
        end
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack) begin
          out50_nxt  = 1'b0;
          out100_nxt = 1'b0;
          if (rest == '0) begin
            state_nxt = DONE;
          end else begin
            gap_nxt   = GAP_W'(GAP_CYCLES);
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        gap_nxt = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = SEL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        out50_nxt  = 1'b0;
        out100_nxt = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_automat_rest.sv
// Bench for automat_rest: cycle-level coin-payout model checked every cycle,
// plus directed payouts with hand-computed coin/done counts.
module tb_automat_rest;

  localparam int unsigned AMT_W      = 3;
  localparam int unsigned GAP_CYCLES = 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             empty100 = 1'b0;
  logic             ack = 1'b0;
  logic             out50, out100, busy, done;

  int checks = 0;
  int failures = 0;

  automat_rest #(.AMT_W(AMT_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock(clock), .reset(reset), .start(start), .amount(amount),
    .empty100(empty100), .ack(ack),
    .out50(out50), .out100(out100), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: remaining units, which coin is being requested
  // (0 none, 1 fifty, 2 hundred), and cycles left before the next coin choice.
  bit m_valid = 0;
  bit m_active, m_done;
  int m_coin, m_rem, m_wait;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1; m_active = 0; m_done = 0; m_coin = 0; m_rem = 0; m_wait = 0;
    end else if (m_valid) begin
      if (m_done) begin
        m_done = 0; m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_rem = int'(amount);
          m_wait = 0;
          if (amount == '0) m_done = 1;
        end
      end else if (m_coin != 0) begin
        if (ack) begin
          m_coin = 0;
          if (m_rem == 0) m_done = 1;
          else m_wait = GAP_CYCLES;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        m_coin = (m_rem >= 2 && !empty100) ? 2 : 1;
        m_rem -= m_coin;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (m_valid) begin
      checks++;
      if ({out50, out100, busy, done} !== {m_coin == 1, m_coin == 2, m_active, m_done}) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual(o50,o100,busy,done)=%b%b%b%b required=%b%b%b%b",
                 $time, out50, out100, busy, done,
                 m_coin == 1, m_coin == 2, m_active, m_done);
      end
    end
  end

  // Pulse counters observed from the DUT
  int n50, n100, ndone, run_w, max_w;
  logic p50 = 1'b0, p100 = 1'b0;
  always @(negedge clock) begin
    if (out50 === 1'b1 && p50 !== 1'b1) n50++;
    if (out100 === 1'b1 && p100 !== 1'b1) n100++;
    if (done === 1'b1) ndone++;
    if (out50 === 1'b1 || out100 === 1'b1) begin
      run_w++;
      if (run_w > max_w) max_w = run_w;
    end else begin
      run_w = 0;
    end
    p50 = out50;
    p100 = out100;
  end

  task automatic clear_counts();
    n50 = 0; n100 = 0; ndone = 0; run_w = 0; max_w = 0;
  endtask

  // One payout; ack_dly=0 holds ack high, otherwise ack rises on the
  // ack_dly-th cycle a request is visible.
  task automatic payout(input string name, input logic [AMT_W-1:0] amt, input bit e100,
                        input int ack_dly, input bit inject, input int exp100,
                        input int exp50, input int exp_w);
    bit seen_done;
    int hold;
    seen_done = 0;
    hold = 0;
    @(negedge clock);
    clear_counts();
    empty100 = e100;
    ack = (ack_dly == 0);
    start = 1'b1;
    amount = amt;
    @(negedge clock);
    start = 1'b0;
    amount = AMT_W'($urandom);
    if (amt == '0) chk({name, "_done_after_1_edge"}, int'(done), 1);
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      if (out50 || out100) begin
        hold++;
        ack = (ack_dly == 0) || (hold >= ack_dly);
      end else begin
        hold = 0;
        ack = (ack_dly == 0);
      end
      if (inject && cyc == 3) begin
        start = 1'b1;
        amount = AMT_W'(1);
      end else begin
        start = 1'b0;
      end
      if (done) seen_done = 1;
      @(negedge clock);
    end
    start = 1'b0;
    ack = 1'b0;
    repeat (3) @(negedge clock);
    chk({name, "_done_seen"}, int'(seen_done), 1);
    chk({name, "_n100"}, n100, exp100);
    chk({name, "_n50"}, n50, exp50);
    chk({name, "_ndone"}, ndone, 1);
    if (exp_w > 0) chk({name, "_req_width"}, max_w, exp_w);
    chk({name, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    // Reset with random inputs for two cycles
    reset = 1'b1;
    repeat (2) begin
      start = 1'($urandom); amount = AMT_W'($urandom);
      empty100 = 1'($urandom); ack = 1'($urandom);
      @(negedge clock);
    end
    chk("reset_outputs", int'({out50, out100, busy, done}), 0);
    start = 1'b0; ack = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    payout("mixed", 3'd3, 1'b0, 2, 1'b0, 1, 1, 2);
    payout("empty_tube", 3'd3, 1'b1, 2, 1'b0, 0, 3, 2);
    payout("zero", 3'd0, 1'b0, 1, 1'b0, 0, 0, 0);
    payout("max", 3'd7, 1'b0, 1, 1'b0, 3, 1, 1);
    payout("ignored_start", 3'd4, 1'b0, 2, 1'b1, 2, 0, 2);
    payout("held_ack", 3'd3, 1'b0, 0, 1'b0, 1, 1, 1);
    payout("held_ack_empty", 3'd2, 1'b1, 0, 1'b0, 0, 2, 1);

    // Reset in the middle of a payout
    @(negedge clock);
    ack = 1'b0;
    empty100 = 1'b0;
    start = 1'b1;
    amount = 3'd5;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && !out100; i++) @(negedge clock);
    chk("midreset_coin_requested", int'(out100), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_outputs", int'({out50, out100, busy, done}), 0);
    reset = 1'b0;
    clear_counts();
    ack = 1'b1;
    repeat (20) @(negedge clock);
    chk("midreset_n100", n100, 0);
    chk("midreset_n50", n50, 0);
    chk("midreset_ndone", ndone, 0);
    chk("midreset_busy", int'(busy), 0);

    // Start accepted again after the aborted payout
    payout("after_reset", 3'd1, 1'b0, 1, 1'b0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
